sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Parametrised multi-channel front end for the single-port SDRAM controller. It replaces the hand-written address/data/strobe muxing in the core top level: ROM download, CPU RAM, cassette reader and similar clients each get an independent request/ack channel. It also absorbs the hard-reset memory clear as a configurable fill engine. It sits between the clients and `sdram` in every core top level.

## Interface
Parameters:
- `NCH`, 4: number of client channels (2..8).
- `AW`, 23: address width.
- `DW`, 8: data width.
- `FILL_AW`, 16: width of the fill length counter.
- `ARB_MODE`, 0: 0 = fixed priority (channel 0 highest); 1 = round-robin.

Ports:
- `clk_sys` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `req_rd` in NCH: per-channel read request, level, held until ack.
- `req_wr` in NCH: per-channel write request, level, held until ack.
- `req_addr` in NCH*AW: channel i occupies bits [i*AW +: AW].
- `req_din` in NCH*DW: write data, packed the same way.
- `req_ack` out NCH: one-cycle completion pulse.
- `rd_valid` out NCH: one-cycle pulse, coincident with ack for reads.
- `rd_data` out DW: registered read data, shared by all channels.
- `fill_start` in 1: pulse; starts a fill.
- `fill_base` in AW: first fill address.
- `fill_len` in FILL_AW: number of locations to fill.
- `fill_value` in DW: fill data.
- `fill_ce` in 1: pacing strobe; one fill write is issued per rising edge.
- `fill_busy` out 1: high while a fill is in progress.
- `fill_done` out 1: one-cycle pulse when a fill completes.
- `mem_addr` out AW: address to the controller.
- `mem_din` out DW: write data to the controller.
- `mem_rd` out 1: read strobe to the controller.
- `mem_we` out 1: write strobe to the controller.
- `mem_dout` in DW: read data from the controller.
- `mem_ready` in 1: command complete; `mem_dout` is valid in that cycle.

## Operation
- One command in flight at a time.
- FSM states: IDLE → ISSUE → ACK → IDLE.
  - IDLE: pick a winner; register its addr, din and direction.
  - ISSUE: hold `mem_rd` or `mem_we` and a stable addr/din until `mem_ready` is sampled high.
  - ACK: strobes low; pulse `req_ack[g]`; for a read, also pulse `rd_valid[g]` and load `rd_data`.
- Eligibility:
  - Channel i is eligible when `req_rd[i] | req_wr[i]` is high.
  - Channel i is **not** eligible in the IDLE cycle immediately after its own ACK. This lets a registered requester drop its request.
  - If both rd and wr are high on one channel, the transaction is a write. No `rd_valid` is produced.
- Fixed mode: the lowest eligible index wins.
- Round-robin mode: the search starts at last grant + 1 and wraps mod NCH. After reset the pointer starts at channel 0.
- Fill engine:
  - A `fill_start` seen while not busy latches base, len and value. Count = len, and `fill_busy` goes to 1.
  - A `fill_start` while busy is ignored.
  - Fill has absolute priority over channels at IDLE. It never preempts a command already in ISSUE.
  - Each fill write needs a `fill_ce` rising edge detected since the previous fill write. This is a 1-deep pending flag.
  - Fill writes go to address base+count-1, in descending order down to base; count decrements at each ACK.
  - When count reaches 0, `fill_busy` goes to 0 and `fill_done` pulses in the same cycle.
  - If `fill_len`=0: `fill_done` pulses in the cycle after start, with no memory writes and `fill_busy` staying 0.
- Address arithmetic is AW bits wide, modulo 2^AW. Base+len overflow wraps.
- Reset behaviour:
  - Reset forces IDLE.
  - All outputs go to 0: `mem_*`, `req_ack`, `rd_valid`, `rd_data`, `fill_busy`, `fill_done`.
  - The fill is cancelled with no `fill_done`, and the round-robin pointer returns to 0.
  - Reset during ISSUE drops the strobe the next cycle. The controller must tolerate an abandoned command.

## Timing
- Request high at IDLE cycle N → `mem_rd`/`mem_we` high from cycle N+1.
- `mem_ready` high at cycle M → ack/`rd_valid`/`rd_data` at M+1, strobes low at M+1, IDLE at M+2.
- Minimum throughput: one command per 3 cycles with a zero-wait controller.
- All outputs are registered. There is no combinational path from `req_*` or `mem_ready` to any output.

## Structure
- Package `sdram_arb_pkg`:
  - state enum (IDLE, ISSUE, ACK);
  - constants ARB_FIXED=0 and ARB_RR=1;
  - a winner-select function prototype.
- Sub-module `rr_priority_pick`: combinational NCH-wide eligible mask plus start pointer → one-hot winner and index. It is used in both modes; fixed mode ties the pointer to 0.
- The fill counter and fill pacing live in the top module.

## Test plan
- Fixed mode, ch1 and ch3 read in the same cycle, addrs 0x000100/0x000300 → ch1 is served first. `mem_addr`=0x000100, then 0x000300; `rd_valid[1]` comes before `rd_valid[3]`.
- Round-robin mode, all 4 channels requesting continuously → grant order 0,1,2,3,0,1. No channel is served twice in succession.
- Fill: base 0x010000, len 4, value 0x00, `fill_ce` every 8 cycles, ch0 requesting throughout → four writes to 0x010003..0x010000 before any ch0 ack. `fill_done` pulses once, and ch0 is served after.
- Fill with `fill_len`=0 → `fill_done` pulses at start+1, `mem_we` never rises, `fill_busy` stays 0.
- Reset asserted during ISSUE, with `mem_ready` held low → next cycle `mem_rd`/`mem_we` are 0. No `req_ack` ever appears, and a subsequent request is served normally.
- ch2 asserts rd and wr, din 0x5A → one `mem_we` with `mem_din`=0x5A, a single `req_ack[2]`, and `rd_valid` stays 0.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and helpers for the SDRAM port arbiter.
//   arb_state_t  - command sequencer states (IDLE -> ISSUE -> ACK)
//   ARB_FIXED/RR - arbitration mode selectors
//   pick_first   - circular first-set search over an eligible mask (up to 8 channels)
package sdram_arb_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_ACK} arb_state_t;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;
   localparam int PICK_MAX  = 8;

   // Returns {found, index}. Search begins at 'start' and wraps modulo n.
   function automatic logic [3:0] pick_first(input logic [7:0] elig,
                                             input logic [2:0] start,
                                             input int         n);
      logic [3:0] r;
      logic [3:0] j;
      r = '0;
      for (int k = 0; k < PICK_MAX; k++) begin
         j = {1'b0, start} + 4'(k);
         if (j >= 4'(n)) j = j - 4'(n);
         if (k < n && !r[3] && elig[j[2:0]]) r = {1'b1, j[2:0]};
      end
      return r;
   endfunction

endpackage

// File: rtl/sdram_port_arbiter_pick.sv
// rr_priority_pick: combinational winner select.
//   elig      - per-channel eligible mask
//   start     - channel where the search begins (0 gives fixed priority)
//   grant_oh  - one-hot winner (all zero when nothing is eligible)
//   grant_idx - winner index
//   any       - at least one channel eligible
module rr_priority_pick
   import sdram_arb_pkg::*;
#(
   parameter int NCH = 4
)(
   input  logic [NCH-1:0]         elig,
   input  logic [$clog2(NCH)-1:0] start,
   output logic [NCH-1:0]         grant_oh,
   output logic [$clog2(NCH)-1:0] grant_idx,
   output logic                   any
);
   localparam int IW = $clog2(NCH);

   logic [3:0] res;

   always_comb begin
      res       = pick_first(8'(elig), 3'(start), NCH);
      any       = res[3];
      grant_idx = IW'(res[2:0]);
      grant_oh  = '0;
      if (res[3]) grant_oh[grant_idx] = 1'b1;
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: multi-channel front end for the single-port SDRAM
// controller, with a paced descending fill engine for memory clearing.
//   clients : req_rd/req_wr/req_addr/req_din in, req_ack/rd_valid/rd_data out
//   fill    : fill_start/base/len/value/ce in, fill_busy/fill_done out
//   memory  : mem_addr/mem_din/mem_rd/mem_we out, mem_dout/mem_ready in
// One command in flight; every output is a flop.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NCH      = 4,
   parameter int AW       = 23,
   parameter int DW       = 8,
   parameter int FILL_AW  = 16,
   parameter int ARB_MODE = ARB_FIXED
)(
   input  logic               clk_sys,
   input  logic               reset,
   input  logic [NCH-1:0]     req_rd,
   input  logic [NCH-1:0]     req_wr,
   input  logic [NCH*AW-1:0]  req_addr,
   input  logic [NCH*DW-1:0]  req_din,
   output logic [NCH-1:0]     req_ack,
   output logic [NCH-1:0]     rd_valid,
   output logic [DW-1:0]      rd_data,
   input  logic               fill_start,
   input  logic [AW-1:0]      fill_base,
   input  logic [FILL_AW-1:0] fill_len,
   input  logic [DW-1:0]      fill_value,
   input  logic               fill_ce,
   output logic               fill_busy,
   output logic               fill_done,
   output logic [AW-1:0]      mem_addr,
   output logic [DW-1:0]      mem_din,
   output logic               mem_rd,
   output logic               mem_we,
   input  logic [DW-1:0]      mem_dout,
   input  logic               mem_ready
);
   localparam int IW = $clog2(NCH);

   arb_state_t         state;
   logic [NCH-1:0]     gnt_oh, blk_mask, elig, pick_oh;
   logic [IW-1:0]      pick_idx, rr_ptr, start_ptr;
   logic               pick_any, is_fill, ce_d, ce_rise, fill_pend;
   logic [AW-1:0]      fill_base_q, fill_addr;
   logic [DW-1:0]      fill_val_q;
   logic [FILL_AW-1:0] fill_cnt;

   // blk_mask hides the channel just acked for one IDLE cycle so a
   // registered requester has time to drop its level request.
   assign elig      = (req_rd | req_wr) & ~blk_mask;
   assign start_ptr = (ARB_MODE == ARB_RR) ? rr_ptr : '0;
   assign ce_rise   = fill_ce & ~ce_d;
   // Fill walks downward: base+count-1 .. base, wrapping modulo 2^AW.
   assign fill_addr = fill_base_q + AW'(fill_cnt) - AW'(1);

   rr_priority_pick #(.NCH(NCH)) u_pick (
      .elig      (elig),
      .start     (start_ptr),
      .grant_oh  (pick_oh),
      .grant_idx (pick_idx),
      .any       (pick_any)
   );

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state       <= ST_IDLE;
         mem_addr    <= '0;
         mem_din     <= '0;
         mem_rd      <= 1'b0;
         mem_we      <= 1'b0;
         req_ack     <= '0;
         rd_valid    <= '0;
         rd_data     <= '0;
         fill_busy   <= 1'b0;
         fill_done   <= 1'b0;
         gnt_oh      <= '0;
         blk_mask    <= '0;
         rr_ptr      <= '0;
         is_fill     <= 1'b0;
         ce_d        <= 1'b0;
         fill_pend   <= 1'b0;
         fill_base_q <= '0;
         fill_val_q  <= '0;
         fill_cnt    <= '0;
      end else begin
         req_ack   <= '0;
         rd_valid  <= '0;
         fill_done <= 1'b0;
         blk_mask  <= '0;
         ce_d      <= fill_ce;

         if (fill_start && !fill_busy) begin
            fill_base_q <= fill_base;
            fill_val_q  <= fill_value;
            fill_cnt    <= fill_len;
            fill_pend   <= 1'b0;
            if (fill_len == '0) fill_done <= 1'b1;
            else                fill_busy <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               // While a fill is active, channels wait even between paced writes.
               if (fill_busy) begin
                  if (fill_pend) begin
                     mem_addr  <= fill_addr;
                     mem_din   <= fill_val_q;
                     mem_we    <= 1'b1;
                     mem_rd    <= 1'b0;
                     is_fill   <= 1'b1;
                     fill_pend <= 1'b0;
                     state     <= ST_ISSUE;
                  end
               end else if (pick_any) begin
                  mem_addr <= req_addr[int'(pick_idx)*AW +: AW];
                  mem_din  <= req_din[int'(pick_idx)*DW +: DW];
                  // rd and wr together resolve to a write.
                  mem_we   <= req_wr[pick_idx];
                  mem_rd   <= ~req_wr[pick_idx];
                  gnt_oh   <= pick_oh;
                  is_fill  <= 1'b0;
                  rr_ptr   <= (pick_idx == IW'(NCH-1)) ? '0 : pick_idx + IW'(1);
                  state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (mem_ready) begin
                  mem_rd <= 1'b0;
                  mem_we <= 1'b0;
                  state  <= ST_ACK;
                  if (is_fill) begin
                     fill_cnt <= fill_cnt - FILL_AW'(1);
                     if (fill_cnt == FILL_AW'(1)) begin
                        fill_busy <= 1'b0;
                        fill_done <= 1'b1;
                     end
                  end else begin
                     req_ack <= gnt_oh;
                     if (mem_rd) begin
                        rd_valid <= gnt_oh;
                        rd_data  <= mem_dout;
                     end
                  end
               end
            end
            ST_ACK: begin
               blk_mask <= is_fill ? '0 : gnt_oh;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         // A new edge wins over the clear from a write issued this cycle.
         if (ce_rise) fill_pend <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench: expected memory commands are queued as stimulus is
// driven and compared as the arbiter completes them; a second instance in
// round-robin mode checks grant rotation.
module tb_sdram_port_arbiter;
   import sdram_arb_pkg::*;

   localparam int NCH = 4, AW = 23, DW = 8, FW = 16;

   typedef struct {
      bit            fill;
      int            ch;
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
   } exp_t;

   logic clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   int n_checks = 0;
   int n_errs   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rdata(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h3C;
   endfunction

   // ---------------- fixed-priority instance ----------------
   logic              reset;
   logic [NCH-1:0]    req_rd, req_wr, req_ack, rd_valid;
   logic [NCH*AW-1:0] req_addr;
   logic [NCH*DW-1:0] req_din;
   logic [DW-1:0]     rd_data, fill_value, mem_din, mem_dout;
   logic              fill_start, fill_busy, fill_done, fill_ce;
   logic [AW-1:0]     fill_base, mem_addr;
   logic [FW-1:0]     fill_len;
   logic              mem_rd, mem_we, mem_ready, stall;
   logic [2:0]        ce_cnt = 3'd0;

   always @(posedge clk_sys) ce_cnt <= ce_cnt + 3'd1;
   assign fill_ce = (ce_cnt == 3'd0);

   sdram_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .FILL_AW(FW), .ARB_MODE(ARB_FIXED)) dut (
      .clk_sys(clk_sys), .reset(reset),
      .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_din(req_din),
      .req_ack(req_ack), .rd_valid(rd_valid), .rd_data(rd_data),
      .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
      .fill_value(fill_value), .fill_ce(fill_ce), .fill_busy(fill_busy), .fill_done(fill_done),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_we(mem_we),
      .mem_dout(mem_dout), .mem_ready(mem_ready)
   );

   always @(posedge clk_sys) begin
      if (reset) begin
         mem_ready <= 1'b0;
         mem_dout  <= '0;
      end else begin
         mem_ready <= (mem_rd | mem_we) && !mem_ready && !stall;
         mem_dout  <= rdata(mem_addr);
      end
   end

   exp_t exp_q[$];
   exp_t cur;
   logic ack_due = 1'b0;
   int   n_fill_done = 0;

   always @(negedge clk_sys) begin
      if (fill_done) n_fill_done <= n_fill_done + 1;
      if (ack_due) begin
         chk("ack", 64'(req_ack), cur.fill ? 64'(0) : (64'(1) << cur.ch));
         chk("rd_valid", 64'(rd_valid), (!cur.fill && !cur.we) ? (64'(1) << cur.ch) : 64'(0));
         if (!cur.fill && !cur.we) chk("rd_data", 64'(rd_data), 64'(rdata(cur.addr)));
         ack_due <= 1'b0;
      end else if ((req_ack | rd_valid) != '0) begin
         chk("spurious_ack", 64'({req_ack, rd_valid}), 64'(0));
      end
      if (!reset && mem_ready && (mem_rd || mem_we)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_cmd_addr", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            chk("cmd_addr", 64'(mem_addr), 64'(exp_q[0].addr));
            chk("cmd_we", 64'(mem_we), 64'(exp_q[0].we));
            chk("cmd_rd", 64'(mem_rd), 64'(!exp_q[0].we));
            if (exp_q[0].we) chk("cmd_din", 64'(mem_din), 64'(exp_q[0].din));
            cur     <= exp_q[0];
            ack_due <= 1'b1;
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic push(input bit fill, input int ch, input bit we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      e.fill = fill; e.ch = ch; e.we = we; e.addr = a; e.din = d;
      exp_q.push_back(e);
   endtask

   task automatic set_req(input int ch, input bit rd, input bit wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_rd[ch] = rd;
      req_wr[ch] = wr;
      req_addr[ch*AW +: AW] = a;
      req_din[ch*DW +: DW]  = d;
   endtask

   // Drops each request on its ack and waits for the scoreboard to drain.
   task automatic run_until_idle(input int max);
      int n;
      n = 0;
      while ((req_rd != '0 || req_wr != '0 || exp_q.size() != 0 || ack_due || fill_busy) && n < max) begin
         @(negedge clk_sys); #1;
         n++;
         for (int i = 0; i < NCH; i++)
            if (req_ack[i]) begin req_rd[i] = 1'b0; req_wr[i] = 1'b0; end
      end
      chk("drain_left", 64'(exp_q.size()), 64'(0));
      chk("drain_reqs", 64'({req_rd, req_wr}), 64'(0));
   endtask

   // ---------------- round-robin instance ----------------
   logic              rr_reset, rr_mem_rd, rr_mem_we, rr_mem_ready, rr_fill_busy, rr_fill_done;
   logic [NCH-1:0]    rr_req_rd, rr_ack, rr_rd_valid;
   logic [NCH*AW-1:0] rr_req_addr;
   logic [DW-1:0]     rr_rd_data, rr_mem_din, rr_mem_dout;
   logic [AW-1:0]     rr_mem_addr;
   logic              rr_done = 1'b0;
   int                rr_exp_q[$];

   sdram_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .FILL_AW(FW), .ARB_MODE(ARB_RR)) dut_rr (
      .clk_sys(clk_sys), .reset(rr_reset),
      .req_rd(rr_req_rd), .req_wr('0), .req_addr(rr_req_addr), .req_din('0),
      .req_ack(rr_ack), .rd_valid(rr_rd_valid), .rd_data(rr_rd_data),
      .fill_start(1'b0), .fill_base('0), .fill_len('0),
      .fill_value('0), .fill_ce(1'b0), .fill_busy(rr_fill_busy), .fill_done(rr_fill_done),
      .mem_addr(rr_mem_addr), .mem_din(rr_mem_din), .mem_rd(rr_mem_rd), .mem_we(rr_mem_we),
      .mem_dout(rr_mem_dout), .mem_ready(rr_mem_ready)
   );

   always @(posedge clk_sys) begin
      if (rr_reset) begin
         rr_mem_ready <= 1'b0;
         rr_mem_dout  <= '0;
      end else begin
         rr_mem_ready <= (rr_mem_rd | rr_mem_we) && !rr_mem_ready;
         rr_mem_dout  <= rdata(rr_mem_addr);
      end
   end

   initial begin
      int n, ch;
      logic [NCH-1:0] extra;
      rr_reset = 1'b1; rr_req_rd = '0; rr_req_addr = '0;
      for (int i = 0; i < NCH; i++) rr_req_addr[i*AW +: AW] = AW'(32'h20 * (i + 1));
      repeat (4) @(posedge clk_sys);
      #1 rr_reset = 1'b0;
      rr_exp_q = '{0, 1, 2, 3, 0, 1};
      @(posedge clk_sys); #1 rr_req_rd = '1;
      n = 0;
      while (rr_exp_q.size() != 0 && n < 300) begin
         @(negedge clk_sys); n++;
         if (rr_ack != '0) begin
            ch = rr_exp_q.pop_front();
            chk("rr_order", 64'(rr_ack), 64'(1) << ch);
            chk("rr_rd_valid", 64'(rr_rd_valid), 64'(rr_ack));
            chk("rr_rd_data", 64'(rr_rd_data), 64'(rdata(AW'(32'h20 * (ch + 1)))));
            if (rr_exp_q.size() == 0) rr_req_rd = '0;
         end
      end
      chk("rr_left", 64'(rr_exp_q.size()), 64'(0));
      extra = '0;
      repeat (10) begin @(negedge clk_sys); extra |= rr_ack; end
      chk("rr_extra_ack", 64'(extra), 64'(0));
      chk("rr_no_write", 64'({rr_mem_we, rr_fill_busy, rr_fill_done, rr_mem_din}), 64'(0));
      rr_done = 1'b1;
   end

   // ---------------- main sequence ----------------
   initial begin
      int n, d0;
      logic we_seen;
      reset = 1'b1; stall = 1'b0;
      req_rd = '0; req_wr = '0; req_addr = '0; req_din = '0;
      fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_value = '0;
      repeat (3) @(posedge clk_sys);
      #1 reset = 1'b0;
      @(negedge clk_sys);
      chk("rst_strobes", 64'({mem_rd, mem_we}), 64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      chk("rst_mem_din", 64'(mem_din), 64'(0));
      chk("rst_ack", 64'({req_ack, rd_valid}), 64'(0));
      chk("rst_rd_data", 64'(rd_data), 64'(0));
      chk("rst_fill", 64'({fill_busy, fill_done}), 64'(0));

      // fixed priority: ch1 beats ch3
      push(0, 1, 0, 23'h000100, 8'h00);
      push(0, 3, 0, 23'h000300, 8'h00);
      @(posedge clk_sys); #1;
      set_req(1, 1, 0, 23'h000100, 8'h00);
      set_req(3, 1, 0, 23'h000300, 8'h00);
      @(posedge clk_sys); #1;
      chk("t1_issue_rd", 64'(mem_rd), 64'(1));
      chk("t1_issue_addr", 64'(mem_addr), 64'h100);
      run_until_idle(200);

      // ch0 write beats ch3 read
      push(0, 0, 1, 23'h000005, 8'h77);
      push(0, 3, 0, 23'h012345, 8'h00);
      @(posedge clk_sys); #1;
      set_req(3, 1, 0, 23'h012345, 8'h00);
      set_req(0, 0, 1, 23'h000005, 8'h77);
      run_until_idle(200);

      // rd+wr together is a write, no rd_valid
      push(0, 2, 1, 23'h002200, 8'h5A);
      @(posedge clk_sys); #1;
      set_req(2, 1, 1, 23'h002200, 8'h5A);
      run_until_idle(200);

      // paced fill ahead of a waiting ch0 read
      for (int k = 3; k >= 0; k--) push(1, 0, 1, AW'(32'h010000 + k), 8'h00);
      push(0, 0, 0, 23'h000040, 8'h00);
      d0 = n_fill_done;
      @(posedge clk_sys); #1;
      fill_base = 23'h010000; fill_len = 16'd4; fill_value = 8'h00; fill_start = 1'b1;
      @(posedge clk_sys); #1;
      fill_start = 1'b0;
      set_req(0, 1, 0, 23'h000040, 8'h00);
      chk("t3_busy", 64'(fill_busy), 64'(1));
      run_until_idle(400);
      @(negedge clk_sys);
      chk("t3_done_cnt", 64'(n_fill_done - d0), 64'(1));

      // fill wrapping past the top of the address space
      push(1, 0, 1, 23'h000001, 8'hC3);
      push(1, 0, 1, 23'h000000, 8'hC3);
      push(1, 0, 1, 23'h7FFFFF, 8'hC3);
      push(1, 0, 1, 23'h7FFFFE, 8'hC3);
      d0 = n_fill_done;
      @(posedge clk_sys); #1;
      fill_base = 23'h7FFFFE; fill_len = 16'd4; fill_value = 8'hC3; fill_start = 1'b1;
      @(posedge clk_sys); #1;
      fill_start = 1'b0;
      run_until_idle(400);
      @(negedge clk_sys);
      chk("wrap_done_cnt", 64'(n_fill_done - d0), 64'(1));

      // zero-length fill
      d0 = n_fill_done;
      @(posedge clk_sys); #1;
      fill_len = '0; fill_start = 1'b1;
      @(posedge clk_sys); #1;
      fill_start = 1'b0;
      @(negedge clk_sys);
      chk("len0_done", 64'(fill_done), 64'(1));
      chk("len0_busy", 64'(fill_busy), 64'(0));
      we_seen = 1'b0;
      repeat (10) begin @(negedge clk_sys); we_seen |= mem_we | fill_busy; end
      chk("len0_no_we", 64'(we_seen), 64'(0));
      chk("len0_done_cnt", 64'(n_fill_done - d0), 64'(1));

      // reset while a read is stalled in ISSUE
      stall = 1'b1;
      @(posedge clk_sys); #1;
      set_req(1, 1, 0, 23'h001111, 8'h00);
      n = 0;
      while (!mem_rd && n < 50) begin @(negedge clk_sys); n++; end
      chk("t5_issue_seen", 64'(mem_rd), 64'(1));
      @(posedge clk_sys); #1 reset = 1'b1;
      @(posedge clk_sys); #1;
      chk("t5_rst_strobes", 64'({mem_rd, mem_we}), 64'(0));
      chk("t5_rst_ack", 64'({req_ack, rd_valid}), 64'(0));
      push(0, 1, 0, 23'h001111, 8'h00);
      reset = 1'b0; stall = 1'b0;
      run_until_idle(200);

      n = 0;
      while (!rr_done && n < 2000) begin @(posedge clk_sys); n++; end
      chk("rr_finished", 64'(rr_done), 64'(1));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
